// File: rtl/enc_dec_apb_master.sv
// APB3 initiator for the enc_dec register file.
// Turns one-beat command requests into SETUP/ACCESS transfers. The result
// comes back on a single-cycle response strobe. Slave wait states are
// bounded by a timeout that aborts the transfer with an error response.
module enc_dec_apb_master #(
    parameter int AMBA_ADDR_WIDTH = 32,
    parameter int AMBA_WORD       = 32,
    parameter int TIMEOUT_CYCLES  = 16,
    parameter int RD_SAMPLE_SETUP = 1
) (
    input  logic                       clk,
    input  logic                       rstn,
    // command side
    input  logic                       cmd_valid,
    output logic                       cmd_ready,
    input  logic                       cmd_write,
    input  logic [AMBA_ADDR_WIDTH-1:0] cmd_addr,
    input  logic [AMBA_WORD-1:0]       cmd_wdata,
    // response side
    output logic                       rsp_valid,
    output logic [AMBA_WORD-1:0]       rsp_rdata,
    output logic                       rsp_err,
    // APB side
    output logic [AMBA_ADDR_WIDTH-1:0] paddr,
    output logic [AMBA_WORD-1:0]       pwdata,
    output logic                       pwrite,
    output logic                       psel,
    output logic                       penable,
    input  logic [AMBA_WORD-1:0]       prdata,
    input  logic                       pready,
    input  logic                       pslverr
);

    // The counter must be able to hold TIMEOUT_CYCLES-1. The +1 keeps the
    // width non-zero when TIMEOUT_CYCLES is 1.
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt_reg;
    logic             accept;
    logic             xfer_done;
    logic             xfer_abort;
    logic [AMBA_WORD-1:0] rd_final;

    // Transfer events decoded from the current state and slave handshake.
    // Abort fires on the edge that ends the TIMEOUT_CYCLES-th consecutive
    // not-ready ACCESS cycle. The counter then still holds TIMEOUT_CYCLES-1.
    always_comb begin
        accept     = cmd_valid && cmd_ready;
        xfer_done  = (state_reg == ST_ACCESS) && pready;
        xfer_abort = (state_reg == ST_ACCESS) && !pready &&
                     (wait_cnt_reg == CNT_W'(TIMEOUT_CYCLES - 1));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state logic. SETUP always lasts exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   if (accept) state_next = ST_SETUP;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: if (xfer_done || xfer_abort) state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Handshake outputs decoded from the state. cmd_ready is also gated
    // by rstn, so nothing can be accepted while reset is held.
    always_comb begin
        cmd_ready = 1'b0;
        psel      = 1'b0;
        penable   = 1'b0;
        case (state_reg)
            ST_IDLE:   cmd_ready = rstn;
            ST_SETUP:  psel = 1'b1;
            ST_ACCESS: begin
                psel    = 1'b1;
                penable = 1'b1;
            end
            default: ;
        endcase
    end

    // Consecutive not-ready ACCESS cycles. The count clears whenever the
    // transfer ends or the FSM is outside ACCESS.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            wait_cnt_reg <= '0;
        end else if ((state_reg == ST_ACCESS) && !pready && !xfer_abort) begin
            wait_cnt_reg <= wait_cnt_reg + 1'b1;
        end else begin
            wait_cnt_reg <= '0;
        end
    end

    // Address/data/direction are latched only on acceptance. This keeps
    // them stable through SETUP and ACCESS, and they hold their values in
    // IDLE. Reads leave pwdata untouched.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            paddr  <= '0;
            pwdata <= '0;
            pwrite <= 1'b0;
        end else if (accept) begin
            paddr  <= cmd_addr;
            pwrite <= cmd_write;
            if (cmd_write) begin
                pwdata <= cmd_wdata;
            end
        end
    end

    // Read-data source. The enc_dec register file only drives prdata
    // during SETUP. That variant captures on the edge ending SETUP.
    // Otherwise prdata is taken live on the completing edge.
    generate
        if (RD_SAMPLE_SETUP != 0) begin : g_setup_capture
            logic [AMBA_WORD-1:0] rd_hold_reg;

            // Capture read data on the edge that ends SETUP.
            always_ff @(posedge clk) begin
                if (!rstn) begin
                    rd_hold_reg <= '0;
                end else if ((state_reg == ST_SETUP) && !pwrite) begin
                    rd_hold_reg <= prdata;
                end
            end

            assign rd_final = rd_hold_reg;
        end else begin : g_access_capture
            assign rd_final = prdata;
        end
    endgenerate

    // Response strobe plus sticky data/error. Data and error change only
    // when a transfer finishes. Writes and aborts return zero data.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            rsp_valid <= xfer_done || xfer_abort;
            if (xfer_abort) begin
                rsp_err   <= 1'b1;
                rsp_rdata <= '0;
            end else if (xfer_done) begin
                rsp_err   <= pslverr;
                rsp_rdata <= pwrite ? '0 : rd_final;
            end
        end
    end

endmodule

// File: tb/tb_enc_dec_apb_master.sv
// Bench for enc_dec_apb_master. Two instances run in lockstep:
// index 0 captures read data in SETUP, index 1 captures at completion.
// Each instance has its own APB slave. The slave serves a fixed wait/error
// plan per transfer and drives noise wherever its outputs are meant to be
// ignored.
module tb_enc_dec_apb_master;

    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int TMO = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;

    logic          cmd_ready [2];
    logic          rsp_valid [2];
    logic          rsp_err   [2];
    logic [DW-1:0] rsp_rdata [2];
    logic [AW-1:0] paddr     [2];
    logic [DW-1:0] pwdata    [2];
    logic          pwrite    [2];
    logic          psel      [2];
    logic          penable   [2];
    logic [DW-1:0] prdata    [2];
    logic          pready    [2];
    logic          pslverr   [2];

    // slave plan for the current transfer
    int            plan_wait = 0;
    bit            plan_err = 1'b0;
    logic          noise_rdy = 1'b0;
    logic          noise_err = 1'b0;
    logic [DW-1:0] noise_word = '0;

    // reference model state
    logic [DW-1:0] ref_mem [16];
    logic [DW-1:0] last_wdata = '0;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    always #5 clk = ~clk;

    function automatic logic [31:0] init_val(input int j);
        return 32'h1000_0000 + 32'(j) * 32'h0101_0101;
    endfunction

    enc_dec_apb_master #(
        .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW),
        .TIMEOUT_CYCLES(TMO), .RD_SAMPLE_SETUP(1)
    ) dut_setup (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[0]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]),
        .paddr(paddr[0]), .pwdata(pwdata[0]), .pwrite(pwrite[0]),
        .psel(psel[0]), .penable(penable[0]),
        .prdata(prdata[0]), .pready(pready[0]), .pslverr(pslverr[0])
    );

    enc_dec_apb_master #(
        .AMBA_ADDR_WIDTH(AW), .AMBA_WORD(DW),
        .TIMEOUT_CYCLES(TMO), .RD_SAMPLE_SETUP(0)
    ) dut_access (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready[1]), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]),
        .paddr(paddr[1]), .pwdata(pwdata[1]), .pwrite(pwrite[1]),
        .psel(psel[1]), .penable(penable[1]),
        .prdata(prdata[1]), .pready(pready[1]), .pslverr(pslverr[1])
    );

    // Noise on slave outputs during cycles the master must ignore.
    always @(negedge clk) begin
        noise_rdy  <= 1'($urandom_range(0, 1));
        noise_err  <= 1'($urandom_range(0, 1));
        noise_word <= $urandom;
    end

    // One APB slave per instance: 16-word memory, plan-driven wait states.
    for (genvar gi = 0; gi < 2; gi++) begin : g_slave
        logic [DW-1:0] mem [16];
        int            acc_cnt;
        logic [3:0]    idx;

        assign idx = paddr[gi][5:2];
        assign pready[gi] = (psel[gi] && penable[gi]) ? (acc_cnt == plan_wait) : noise_rdy;
        assign pslverr[gi] = (psel[gi] && penable[gi] && pready[gi]) ? plan_err : noise_err;

        if (gi == 0) begin : g_setup_drive
            assign prdata[gi] = (psel[gi] && !penable[gi]) ? mem[idx] : noise_word;
        end else begin : g_access_drive
            assign prdata[gi] = (psel[gi] && penable[gi] && pready[gi]) ? mem[idx] : noise_word;
        end

        initial begin
            for (int j = 0; j < 16; j++) mem[j] <= init_val(j);
        end

        always @(posedge clk) begin
            if (!rstn || !(psel[gi] && penable[gi])) acc_cnt <= 0;
            else acc_cnt <= acc_cnt + 1;
            if (psel[gi] && penable[gi] && pready[gi] && pwrite[gi] && !pslverr[gi])
                mem[idx] <= pwdata[gi];
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    // Reference model. A transfer either completes after `waits` not-ready
    // cycles or aborts once the slave has been not-ready TMO times.
    task automatic model_step(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                              input int waits, input bit err,
                              output logic [31:0] e_rdata, output bit e_err, output int e_lat);
        if (waits >= TMO) begin
            e_err   = 1'b1;
            e_rdata = '0;
            e_lat   = 2 + TMO;
        end else begin
            e_err   = err;
            e_rdata = wr ? 32'h0 : ref_mem[addr[5:2]];
            e_lat   = 3 + waits;
            if (wr && !err) ref_mem[addr[5:2]] = wdata;
        end
    endtask

    task automatic wait_ready(input string nm);
        int n = 0;
        @(negedge clk);
        while (!(cmd_ready[0] && cmd_ready[1]) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk({nm, "_ready"}, 64'(cmd_ready[0] & cmd_ready[1]), 64'd1);
    endtask

    // Issue one command and check both instances through the response cycle.
    task automatic run_txn(input string nm, input bit wr, input logic [31:0] addr,
                           input logic [31:0] wdata, input int waits, input bit err,
                           input logic [31:0] e_rdata, input bit e_err, input int e_lat);
        int lat;
        int pen [2];
        bit stable [2];
        bit got;
        int e_pen;
        logic [31:0] e_pwdata;
        e_pen = (waits >= TMO) ? TMO : waits + 1;
        plan_wait = waits;
        plan_err  = err;
        wait_ready(nm);
        e_pwdata = wr ? wdata : last_wdata;
        if (wr) last_wdata = wdata;
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = $urandom;
        cmd_wdata = $urandom;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_i%0d_setup_ctl", nm, i), {psel[i], penable[i], pwrite[i]}, {1'b1, 1'b0, wr});
            chk($sformatf("%s_i%0d_setup_paddr", nm, i), paddr[i], addr);
            chk($sformatf("%s_i%0d_setup_pwdata", nm, i), pwdata[i], e_pwdata);
            pen[i] = 0;
            stable[i] = 1'b1;
        end
        lat = 1;
        got = 1'b0;
        while (!got && lat < 40) begin
            for (int i = 0; i < 2; i++) begin
                if (penable[i]) pen[i]++;
                if (!psel[i] || paddr[i] !== addr || pwrite[i] !== wr || pwdata[i] !== e_pwdata)
                    stable[i] = 1'b0;
            end
            @(negedge clk);
            lat++;
            got = rsp_valid[0] | rsp_valid[1];
        end
        chk({nm, "_latency"}, got ? 64'(lat) : 64'hFFFF, 64'(e_lat));
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_i%0d_rsp_valid", nm, i), rsp_valid[i], 1'b1);
            chk($sformatf("%s_i%0d_rsp_err", nm, i), rsp_err[i], e_err);
            chk($sformatf("%s_i%0d_rsp_rdata", nm, i), rsp_rdata[i], e_rdata);
            chk($sformatf("%s_i%0d_rsp_bus", nm, i), {cmd_ready[i], psel[i], penable[i]}, 3'b100);
            chk($sformatf("%s_i%0d_penable_cycles", nm, i), 64'(pen[i]), 64'(e_pen));
            chk($sformatf("%s_i%0d_stable", nm, i), stable[i], 1'b1);
        end
        $display("txn %s wr=%0d addr=%h waits=%0d lat=%0d rdata0=%h rdata1=%h err=%0d/%0d",
                 nm, wr, addr, waits, lat, rsp_rdata[0], rsp_rdata[1], rsp_err[0], rsp_err[1]);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("%s_i%0d_pulse_end", nm, i), rsp_valid[i], 1'b0);
            chk($sformatf("%s_i%0d_hold", nm, i), {rsp_err[i], rsp_rdata[i]}, {e_err, e_rdata});
        end
    endtask

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        logic [31:0] e_rdata;
        bit          e_err;
        int          e_lat;
    } vec_t;

    vec_t vecs [11];

    // Four writes with cmd_valid held high: pulses 3 cycles apart, one idle
    // APB cycle between transfers, addresses issued in order.
    task automatic run_b2b();
        logic [31:0] addrs [4];
        logic [31:0] dat [4];
        int          rsp_cyc [$];
        logic [31:0] seen_addr [$];
        int          k;
        int          gaps;
        int          diverge;
        bit          pend;
        logic [31:0] d_r;
        bit          d_e;
        int          d_l;
        for (int j = 0; j < 4; j++) begin
            addrs[j] = 32'(j * 4);
            dat[j]   = 32'hB0B0_0000 + 32'(j);
            model_step(1'b1, addrs[j], dat[j], 0, 1'b0, d_r, d_e, d_l);
        end
        plan_wait = 0;
        plan_err  = 1'b0;
        wait_ready("b2b");
        k = 0;
        cmd_valid = 1'b1;
        cmd_write = 1'b1;
        cmd_addr  = addrs[0];
        cmd_wdata = dat[0];
        pend = cmd_ready[0];
        gaps = 0;
        diverge = 0;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (pend) begin
                k++;
                if (k < 4) begin
                    cmd_addr  = addrs[k];
                    cmd_wdata = dat[k];
                end else begin
                    cmd_valid = 1'b0;
                end
                pend = 1'b0;
            end
            if (cmd_valid && cmd_ready[0]) pend = 1'b1;
            if (rsp_valid[0]) rsp_cyc.push_back(c);
            if (psel[0] && !penable[0]) seen_addr.push_back(paddr[0]);
            if (seen_addr.size() > 0 && rsp_cyc.size() < 4 && !psel[0]) gaps++;
            if (rsp_valid[0] !== rsp_valid[1] || psel[0] !== psel[1] || paddr[0] !== paddr[1])
                diverge++;
        end
        cmd_valid = 1'b0;
        last_wdata = dat[3];
        chk("b2b_rsp_count", 64'(rsp_cyc.size()), 64'd4);
        for (int j = 1; j < 4; j++)
            chk($sformatf("b2b_spacing%0d", j),
                (j < rsp_cyc.size()) ? 64'(rsp_cyc[j] - rsp_cyc[j-1]) : 64'hFFFF, 64'd3);
        for (int j = 0; j < 4; j++)
            chk($sformatf("b2b_addr%0d", j),
                (j < seen_addr.size()) ? 64'(seen_addr[j]) : 64'hDEAD_0000_0000, 64'(addrs[j]));
        chk("b2b_idle_gaps", 64'(gaps), 64'd3);
        chk("b2b_lockstep", 64'(diverge), 64'd0);
        $display("txn b2b pulses=%0d gaps=%0d", rsp_cyc.size(), gaps);
    endtask

    // Reset asserted for one cycle during ACCESS of a read.
    task automatic run_reset_mid();
        int stray = 0;
        plan_wait = 2;
        plan_err  = 1'b0;
        wait_ready("rst_mid");
        cmd_valid = 1'b1;
        cmd_write = 1'b0;
        cmd_addr  = 32'hC;
        @(negedge clk);
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_mid_in_access", {penable[0], penable[1]}, 2'b11);
        rstn = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_mid_i%0d_ctl", i),
                {cmd_ready[i], psel[i], penable[i], rsp_valid[i]}, 4'b0000);
            chk($sformatf("rst_mid_i%0d_paddr", i), paddr[i], 32'h0);
        end
        rstn = 1'b1;
        last_wdata = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid[0] || rsp_valid[1]) stray++;
        end
        chk("rst_mid_no_rsp", 64'(stray), 64'd0);
        $display("txn rst_mid stray_rsp=%0d", stray);
    endtask

    initial begin
        logic [31:0] e_r;
        bit          e_e;
        int          e_l;
        bit          wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        int          waits;
        bit          err;
        int          r;

        for (int j = 0; j < 16; j++) ref_mem[j] = init_val(j);

        //             wr    addr           wdata          waits err   e_rdata        e_err e_lat
        vecs[0]  = '{1'b1, 32'h0,  32'h0000_0001, 0, 1'b0, 32'h0,         1'b0, 3};
        vecs[1]  = '{1'b1, 32'h4,  32'hA5A5_1234, 0, 1'b0, 32'h0,         1'b0, 3};
        vecs[2]  = '{1'b0, 32'h4,  32'h0,         0, 1'b0, 32'hA5A5_1234, 1'b0, 3};
        vecs[3]  = '{1'b0, 32'h0,  32'h0,         0, 1'b0, 32'h0000_0001, 1'b0, 3};
        vecs[4]  = '{1'b1, 32'h8,  32'h0000_0020, 0, 1'b0, 32'h0,         1'b0, 3};
        vecs[5]  = '{1'b0, 32'h8,  32'h0,         3, 1'b1, 32'h0000_0020, 1'b1, 6};
        vecs[6]  = '{1'b1, 32'h10, 32'h0000_FFFF, 1, 1'b1, 32'h0,         1'b1, 4};
        vecs[7]  = '{1'b0, 32'h10, 32'h0,         0, 1'b0, 32'h1404_0404, 1'b0, 3};
        vecs[8]  = '{1'b0, 32'hC,  32'h0,         9, 1'b0, 32'h0,         1'b1, 6};
        vecs[9]  = '{1'b1, 32'h14, 32'h0000_5555, 4, 1'b0, 32'h0,         1'b1, 6};
        vecs[10] = '{1'b0, 32'h14, 32'h0,         0, 1'b0, 32'h1505_0505, 1'b0, 3};

        // reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rst_i%0d_ctl", i),
                {cmd_ready[i], psel[i], penable[i], pwrite[i], rsp_valid[i], rsp_err[i]}, 6'b0);
            chk($sformatf("rst_i%0d_paddr", i), paddr[i], 32'h0);
            chk($sformatf("rst_i%0d_pwdata", i), pwdata[i], 32'h0);
            chk($sformatf("rst_i%0d_rdata", i), rsp_rdata[i], 32'h0);
        end
        rstn = 1'b1;

        // directed vectors
        for (int v = 0; v < 11; v++) begin
            model_step(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].waits, vecs[v].err,
                       e_r, e_e, e_l);
            run_txn($sformatf("vec%0d", v), vecs[v].wr, vecs[v].addr, vecs[v].wdata,
                    vecs[v].waits, vecs[v].err, vecs[v].e_rdata, vecs[v].e_err, vecs[v].e_lat);
        end

        run_b2b();

        run_reset_mid();
        model_step(1'b0, 32'hC, 32'h0, 0, 1'b0, e_r, e_e, e_l);
        run_txn("rd_0c_after_rst", 1'b0, 32'hC, 32'h0, 0, 1'b0, e_r, e_e, e_l);

        // randomized traffic against the reference model
        for (int t = 0; t < 40; t++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = 32'($urandom_range(0, 15)) << 2;
            wdata = $urandom;
            r     = int'($urandom_range(0, 9));
            waits = (r < 5) ? 0 : r - 4;
            err   = ($urandom_range(0, 3) == 0);
            model_step(wr, addr, wdata, waits, err, e_r, e_e, e_l);
            run_txn($sformatf("rnd%0d", t), wr, addr, wdata, waits, err, e_r, e_e, e_l);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, passed %0d of %0d", pass_cnt, chk_cnt);
        $fatal(1);
    end

endmodule
